core_fetch_port: RTL and testbench

Instruction-side bus master that sits directly upstream of the fetch stage. It turns the fetch stage's fetch/addr request into single pipelined Avalon-MM reads and returns exactly one fetched pulse, with data, per accepted request. It also detects bus error responses and read timeouts, reports them as a fetch fault, and drains late responses so that request/response pairing is never lost.

---
 rtl/core_fetch_port_if.sv | 25 ++
 rtl/core_fetch_port.sv | 115 +++++++++++
 tb/tb_core_fetch_port.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_fetch_port_if.sv
// Fetch-stage request/response and Avalon-MM instruction read signals of core_fetch_port.
// The master modport is the port's view; slave is the fetch stage / interconnect view.
interface core_fetch_port_if;
  logic        fetch;
  logic [29:0] addr;
  logic        fetched;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [1:0]  mem_response;

  modport master (
    input  fetch, addr, mem_waitrequest, mem_readdata, mem_readdatavalid, mem_response,
    output fetched, fetch_data, fetch_fault, mem_address, mem_read
  );

  modport slave (
    output fetch, addr, mem_waitrequest, mem_readdata, mem_readdatavalid, mem_response,
    input  fetched, fetch_data, fetch_fault, mem_address, mem_read
  );
endinterface

// File: rtl/core_fetch_port.sv
// Instruction-side Avalon-MM read master: one read in flight, one fetched pulse per request,
// bus-error / timeout faults, and draining of a late response after a timeout.
module core_fetch_port #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  core_fetch_port_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_read_q, mem_read_d;
  logic [31:0]        mem_address_q, mem_address_d;
  logic               fetched_q, fetched_d;
  logic               fetch_fault_q, fetch_fault_d;
  logic [31:0]        fetch_data_q, fetch_data_d;
  logic               timeout_c;

  // Last WAIT cycle before a forced faulting completion.
  assign timeout_c = TO_EN && (cnt_q == CNT_LAST);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      fetched_q     <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      fetched_q     <= fetched_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.fetch)              state_d = S_REQ;
      S_REQ:   if (!bus.mem_waitrequest)   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_readdatavalid)         state_d = S_IDLE;
        else if (timeout_c)                state_d = S_DRAIN;
      end
      S_DRAIN: if (bus.mem_readdatavalid)  state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; fetched and fetch_fault are single-cycle pulses.
  always_comb begin
    cnt_d         = cnt_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    fetched_d     = 1'b0;
    fetch_fault_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.fetch) begin
          mem_address_d = {bus.addr, 2'b00};
          mem_read_d    = 1'b1;
        end
      end
      S_REQ: begin
        if (!bus.mem_waitrequest) begin
          mem_read_d = 1'b0;
          cnt_d      = '0;
        end
      end
      S_WAIT: begin
        if (bus.mem_readdatavalid) begin
          fetch_data_d  = bus.mem_readdata;
          fetched_d     = 1'b1;
          fetch_fault_d = (bus.mem_response != 2'b00);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_c) begin
            fetched_d     = 1'b1;
            fetch_fault_d = 1'b1;
            fetch_data_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;
  assign bus.fetched     = fetched_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_core_fetch_port.sv
// Directed bench for core_fetch_port: vector table of single transactions plus hand-written
// sequences for back-to-back, timeout/drain, stray responses and asynchronous reset.
module tb_core_fetch_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  core_fetch_port_if bus ();

  core_fetch_port #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [29:0] a;
    int          waitc;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One fetch through REQ (optionally stalled) and WAIT, response after lat cycles.
  task automatic run_vec(input int idx, input vec_t v);
    string n;
    n = $sformatf("v%0d", idx);
    bus.fetch = 1'b1;
    bus.addr  = v.a;
    tick();
    chk({n, ".read"}, 32'(bus.mem_read), 32'd1);
    chk({n, ".addr"}, bus.mem_address, v.exp_addr);
    bus.fetch = 1'b0;
    if (v.waitc > 0) begin
      bus.mem_waitrequest = 1'b1;
      for (int i = 0; i < v.waitc; i++) begin
        bus.addr  = 30'h200 ^ 30'(i);
        bus.fetch = i[0];
        tick();
        chk({n, ".stall_read"}, 32'(bus.mem_read), 32'd1);
        chk({n, ".stall_addr"}, bus.mem_address, v.exp_addr);
      end
    end
    bus.fetch           = 1'b0;
    bus.mem_waitrequest = 1'b0;
    tick();
    chk({n, ".accepted"}, 32'(bus.mem_read), 32'd0);
    for (int i = 1; i < v.lat; i++) begin
      tick();
      chk({n, ".wait_read"}, 32'(bus.mem_read), 32'd0);
      chk({n, ".wait_fetched"}, 32'(bus.fetched), 32'd0);
    end
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = v.rdata;
    bus.mem_response      = v.resp;
    tick();
    bus.mem_readdatavalid = 1'b0;
    bus.mem_response      = 2'b00;
    chk({n, ".fetched"}, 32'(bus.fetched), 32'd1);
    chk({n, ".data"}, bus.fetch_data, v.rdata);
    chk({n, ".fault"}, 32'(bus.fetch_fault), 32'(v.exp_fault));
    tick();
    chk({n, ".pulse_end"}, 32'(bus.fetched), 32'd0);
    chk({n, ".fault_end"}, 32'(bus.fetch_fault), 32'd0);
    chk({n, ".data_held"}, bus.fetch_data, v.rdata);
  endtask

  // Finish a read whose mem_read cycle is the current one, no stall, 1-cycle bus.
  task automatic finish_read(input string n, input logic [31:0] rdata);
    bus.fetch = 1'b0;
    tick();
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = rdata;
    tick();
    bus.mem_readdatavalid = 1'b0;
    chk({n, ".fetched"}, 32'(bus.fetched), 32'd1);
    chk({n, ".data"}, bus.fetch_data, rdata);
    chk({n, ".fault"}, 32'(bus.fetch_fault), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  found;

    vecs[0] = '{30'h100,      0, 1, 32'hDEADBEEF, 2'b00, 32'h0000_0400, 1'b0};
    vecs[1] = '{30'h100,      4, 1, 32'h12345678, 2'b00, 32'h0000_0400, 1'b0};
    vecs[2] = '{30'h3FFFFFFF, 0, 3, 32'hCAFEF00D, 2'b10, 32'hFFFF_FFFC, 1'b1};
    vecs[3] = '{30'h2A,       2, 5, 32'h0BADF00D, 2'b01, 32'h0000_00A8, 1'b1};
    vecs[4] = '{30'h7,        0, 2, 32'h00000001, 2'b11, 32'h0000_001C, 1'b1};
    vecs[5] = '{30'h1,        1, 7, 32'hFFFFFFFF, 2'b00, 32'h0000_0004, 1'b0};
    vecs[6] = '{30'h10,       0, 8, 32'h55AA55AA, 2'b00, 32'h0000_0040, 1'b0};

    bus.fetch             = 1'b0;
    bus.addr              = '0;
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdata      = '0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_response      = 2'b00;

    tick(); tick();
    chk("rst.read",    32'(bus.mem_read), 32'd0);
    chk("rst.addr",    bus.mem_address, 32'd0);
    chk("rst.fetched", 32'(bus.fetched), 32'd0);
    chk("rst.fault",   32'(bus.fetch_fault), 32'd0);
    chk("rst.data",    bus.fetch_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Stray response while idle is ignored.
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h1111_2222;
    tick();
    bus.mem_readdatavalid = 1'b0;
    chk("stray.fetched", 32'(bus.fetched), 32'd0);
    chk("stray.read",    32'(bus.mem_read), 32'd0);
    chk("stray.data",    bus.fetch_data, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Back-to-back with post-increment address captured on the fetched cycle.
    bus.fetch = 1'b1;
    bus.addr  = 30'd0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b%0d.read", k), 32'(bus.mem_read), 32'd1);
      chk($sformatf("b2b%0d.addr", k), bus.mem_address, 32'(k * 4));
      tick();
      chk($sformatf("b2b%0d.one_out", k), 32'(bus.mem_read), 32'd0);
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata      = 32'hA000_0000 + 32'(k);
      tick();
      bus.mem_readdatavalid = 1'b0;
      chk($sformatf("b2b%0d.fetched", k), 32'(bus.fetched), 32'd1);
      chk($sformatf("b2b%0d.data", k), bus.fetch_data, 32'hA000_0000 + 32'(k));
      chk($sformatf("b2b%0d.no_read", k), 32'(bus.mem_read), 32'd0);
      bus.addr = 30'(k + 1);
      tick();
    end
    chk("b2b4.read", 32'(bus.mem_read), 32'd1);
    chk("b2b4.addr", bus.mem_address, 32'h10);
    finish_read("b2b4", 32'hA000_0004);

    // Timeout: fault 8 cycles into WAIT, late response drained silently.
    bus.fetch = 1'b1;
    bus.addr  = 30'h50;
    tick();
    chk("to.addr", bus.mem_address, 32'h140);
    bus.fetch = 1'b0;
    tick();
    w = 0;
    found = 1'b0;
    while (w < 20 && !found) begin
      tick();
      w++;
      if (bus.fetched) found = 1'b1;
    end
    chk("to.seen",    32'(found), 32'd1);
    chk("to.latency", 32'(w), 32'd8);
    chk("to.fault",   32'(bus.fetch_fault), 32'd1);
    chk("to.data",    bus.fetch_data, 32'd0);
    bus.fetch = 1'b1;
    bus.addr  = 30'h60;
    for (int i = 9; i <= 11; i++) begin
      tick();
      chk($sformatf("drain%0d.read", i), 32'(bus.mem_read), 32'd0);
      chk($sformatf("drain%0d.fetched", i), 32'(bus.fetched), 32'd0);
    end
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h0000_0BAD;
    tick();
    bus.mem_readdatavalid = 1'b0;
    chk("drain.swallowed", 32'(bus.fetched), 32'd0);
    chk("drain.no_read",   32'(bus.mem_read), 32'd0);
    tick();
    chk("resume.read", 32'(bus.mem_read), 32'd1);
    chk("resume.addr", bus.mem_address, 32'h180);
    finish_read("resume", 32'h0000_600D);

    // Reset while in REQ (stalled).
    bus.fetch           = 1'b1;
    bus.addr            = 30'h11;
    bus.mem_waitrequest = 1'b1;
    tick();
    chk("rreq.read_pre", 32'(bus.mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq.read", 32'(bus.mem_read), 32'd0);
    chk("rreq.addr", bus.mem_address, 32'd0);
    chk("rreq.data", bus.fetch_data, 32'd0);
    bus.mem_waitrequest = 1'b0;
    bus.addr            = 30'h33;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rreq.fresh_read", 32'(bus.mem_read), 32'd1);
    chk("rreq.fresh_addr", bus.mem_address, 32'hCC);
    finish_read("rreq", 32'h0000_0077);

    // Reset while in WAIT.
    bus.fetch = 1'b1;
    bus.addr  = 30'h44;
    tick();
    bus.fetch = 1'b0;
    tick();
    chk("rwait.read_pre", 32'(bus.mem_read), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rwait.data",    bus.fetch_data, 32'd0);
    chk("rwait.addr",    bus.mem_address, 32'd0);
    chk("rwait.fetched", 32'(bus.fetched), 32'd0);
    chk("rwait.fault",   32'(bus.fetch_fault), 32'd0);
    bus.fetch = 1'b1;
    bus.addr  = 30'h55;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rwait.fresh_read", 32'(bus.mem_read), 32'd1);
    chk("rwait.fresh_addr", bus.mem_address, 32'h154);
    finish_read("rwait", 32'h0000_0099);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
